conv_1d_line_sched: RTL and testbench
=====================================

CONV_1D_LINE_SCHED -- requirements
Module: conv_1d_line_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per element.
REQ-002 SHALL have parameter IMG_W, default 32: input line length in pixels.
REQ-003 SHALL have parameter IMG_D, default 8: input channels.
REQ-004 SHALL have parameter FILTER_L, default 3: filter taps.
REQ-005 SHALL have parameter RESULT_D, default 8: output channels.
REQ-006 SHALL have parameter STRIDE_W, default 1: filter stride.
REQ-007 SHALL have parameter PIPE_LAT, default 6: datapath latency in cycles, at least 1.
REQ-008 SHALL derive RESULT_W = (IMG_W-FILTER_L)/STRIDE_W+1; it is not set manually.
REQ-009 SHALL have one clock and a synchronous, active-high reset.
REQ-010 SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  pixel beat valid
- in_ready  out  1  pixel beat accepted
- in_data  in  DATA_WIDTH*IMG_D  one pixel, all channels; channel k at bits [k*DW +: DW]
- in_last  in  1  producer marks final pixel of line
- lines_in  out  DATA_WIDTH*IMG_D*IMG_W  to datapath; channel k, pixel w at bits [(k*IMG_W+w)*DW +: DW]
- lines_out  in  DATA_WIDTH*RESULT_D*RESULT_W  from datapath; channel i, column j at bits [(i*RESULT_W+j)*DW +: DW]
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_WIDTH*RESULT_D  one result column, channel i at bits [i*DW +: DW]
- out_last  out  1  final column of line
- err  out  1  sticky framing error

Function
REQ-011 SHALL implement states LOAD, WAIT and DRAIN.
REQ-012 SHALL decode in_ready = (state==LOAD) & ~reset.
REQ-013 LOAD: each in_valid&in_ready beat SHALL write in_data into lines_in at pixel index pix_cnt, then increment pix_cnt.
REQ-014 LOAD: the beat with pix_cnt==IMG_W-1 SHALL clear pix_cnt and move to WAIT.
REQ-015 SHALL hold lines_in stable throughout WAIT and DRAIN; pixels not yet rewritten keep their previous-line values.
REQ-016 WAIT: a counter SHALL run from 0; on the cycle where it equals PIPE_LAT-1, lines_out SHALL be captured into a result register and the state moves to DRAIN.
REQ-017 For the last input beat accepted at edge T, the capture SHALL occur at edge T+PIPE_LAT and out_valid SHALL first be high in the following cycle.
REQ-018 DRAIN: out_valid SHALL be high and out_data SHALL present column col_cnt of the result register.
REQ-019 DRAIN: out_last SHALL equal (col_cnt==RESULT_W-1).
REQ-020 DRAIN: on out_valid&out_ready, col_cnt SHALL increment.
REQ-021 DRAIN: accepting the last column SHALL clear col_cnt and return to LOAD, with in_ready high in the next cycle.
REQ-022 While out_ready is low, out_data and out_last SHALL stay stable.
REQ-023 In WAIT and DRAIN, in_valid SHALL be ignored and no beat consumed.
REQ-024 err SHALL set and stay set until reset when in_last=1 is accepted with pix_cnt!=IMG_W-1.
REQ-025 err SHALL set and stay set until reset when in_last=0 is accepted with pix_cnt==IMG_W-1.
REQ-026 A framing error SHALL NOT alter sequencing; the line is always delimited by count.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL set state=LOAD and clear pix_cnt, the WAIT counter, col_cnt, the result register, lines_in and err.
REQ-028 During reset, out_valid, out_last and in_ready SHALL be 0.
REQ-029 Reset asserted mid-LOAD, mid-WAIT or mid-DRAIN SHALL abandon the line, with no partial output after reset.

Configuration
REQ-030 With macro CONV1D_SCHED_PERF_EN defined, the block SHALL add output port line_cnt (32 bits), incremented when the last column is accepted.
REQ-031 With CONV1D_SCHED_PERF_EN defined, the block SHALL add output port stall_cnt (32 bits), incremented on each cycle with out_valid&~out_ready.
REQ-032 Both counters SHALL reset to 0 and wrap modulo 2^32.
REQ-033 Without CONV1D_SCHED_PERF_EN, neither port nor either counter SHALL exist; all other behaviour is identical.

Verification
REQ-034 Defaults; after reset, 32 beats with pixel w, channel k = w+k, in_last on beat 31 -> lines_in element (k,w)=w+k; out_valid first high 7 cycles after the edge accepting beat 31; err=0.
REQ-035 Model datapath returns column j, channel i = i*30+j; out_ready held 1 -> 30 consecutive beats, out_data channel i = i*30+j, out_last only on beat 29, in_ready high the cycle after.
REQ-036 out_ready toggled 1,0,0,1 during DRAIN -> data held while stalled; no column lost or repeated.
REQ-037 in_last asserted on beat 10 -> err rises the next cycle and stays 1; line still completes after 32 beats.
REQ-038 Reset pulsed during DRAIN at column 5 -> out_valid=0 next cycle, in_ready=1; a new line processes normally.
REQ-039 CONV1D_SCHED_PERF_EN defined; two lines with 4 stall cycles total -> line_cnt=2, stall_cnt=4.

Source files
------------

// File: rtl/conv_1d_line_sched.sv
// conv_1d_line_sched: buffers one input line for a conv datapath, waits PIPE_LAT cycles, then streams result columns (ports: in_* pixel stream, lines_in/lines_out datapath bus, out_* column stream, err; CONV1D_SCHED_PERF_EN adds line_cnt/stall_cnt)
module conv_1d_line_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_D      = 8,
  parameter int FILTER_L   = 3,
  parameter int RESULT_D   = 8,
  parameter int STRIDE_W   = 1,
  parameter int PIPE_LAT   = 6,
  localparam int RESULT_W  = (IMG_W - FILTER_L) / STRIDE_W + 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_WIDTH*IMG_D-1:0]             in_data,
  input  logic                                    in_last,
  output logic [DATA_WIDTH*IMG_D*IMG_W-1:0]       lines_in,
  input  logic [DATA_WIDTH*RESULT_D*RESULT_W-1:0] lines_out,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH*RESULT_D-1:0]          out_data,
  output logic                                    out_last,
  output logic                                    err
`ifdef CONV1D_SCHED_PERF_EN
  ,
  output logic [31:0]                             line_cnt,
  output logic [31:0]                             stall_cnt
`endif
);
  localparam int PW = $clog2(IMG_W + 1);
  localparam int CW = $clog2(RESULT_W + 1);
  localparam int LW = $clog2(PIPE_LAT + 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(RESULT_W - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(PIPE_LAT - 1);
  typedef enum logic [1:0] {LOAD, WAIT, DRAIN} state_t;
  state_t                                  r_state;
  logic [PW-1:0]                           r_pix;
  logic [CW-1:0]                           r_col;
  logic [LW-1:0]                           r_lat;
  logic [DATA_WIDTH*IMG_D*IMG_W-1:0]       r_lines;
  logic [DATA_WIDTH*RESULT_D*RESULT_W-1:0] r_res;
  logic                                    r_err;
  logic                                    w_pix_last;
  logic                                    w_col_last;
  assign w_pix_last = r_pix == PIX_LAST;
  assign w_col_last = r_col == COL_LAST;
  assign in_ready   = (r_state == LOAD) & ~reset;
  assign out_valid  = (r_state == DRAIN) & ~reset;
  assign out_last   = out_valid & w_col_last;
  assign lines_in   = r_lines;
  assign err        = r_err;
  always_comb begin
    out_data = '0;
    for (int i = 0; i < RESULT_D; i++)
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_res[(i*RESULT_W + int'(r_col))*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
      r_pix   <= '0;
      r_col   <= '0;
      r_lat   <= '0;
      r_lines <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: if (in_valid) begin
          for (int k = 0; k < IMG_D; k++)
            r_lines[(k*IMG_W + int'(r_pix))*DATA_WIDTH +: DATA_WIDTH] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
          if (in_last != w_pix_last) r_err <= 1'b1;
          r_pix   <= w_pix_last ? '0 : r_pix + PW'(1);
          r_state <= w_pix_last ? WAIT : LOAD;
        end
        WAIT: begin
          r_lat   <= (r_lat == LAT_LAST) ? '0 : r_lat + LW'(1);
          r_state <= (r_lat == LAT_LAST) ? DRAIN : WAIT;
          if (r_lat == LAT_LAST) r_res <= lines_out;
        end
        DRAIN: if (out_ready) begin
          r_col   <= w_col_last ? '0 : r_col + CW'(1);
          r_state <= w_col_last ? LOAD : DRAIN;
        end
        default: r_state <= LOAD;
      endcase
    end
  end
`ifdef CONV1D_SCHED_PERF_EN
  logic [31:0] r_line_cnt;
  logic [31:0] r_stall_cnt;
  assign line_cnt  = r_line_cnt;
  assign stall_cnt = r_stall_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_line_cnt  <= r_line_cnt + 32'(out_valid & out_ready & w_col_last);
      r_stall_cnt <= r_stall_cnt + 32'(out_valid & ~out_ready);
    end
  end
`endif
endmodule

// File: tb/tb_conv_1d_line_sched.sv
// tb_conv_1d_line_sched: directed self-checking bench for conv_1d_line_sched
module tb_conv_1d_line_sched;
  localparam int DW = 8, W = 32, D = 8, RD = 8, RW = 30, LAT = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic [DW*D-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, err;
  logic [DW*D*W-1:0] lines_in;
  logic [DW*RD*RW-1:0] lines_out, good_vec;
  logic [DW*RD-1:0] out_data;
  logic dp_good = 1'b0;
  int errors = 0;
  int checks = 0;
`ifdef CONV1D_SCHED_PERF_EN
  logic [31:0] line_cnt, stall_cnt;
`endif
  conv_1d_line_sched dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .lines_in(lines_in), .lines_out(lines_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .err(err)
`ifdef CONV1D_SCHED_PERF_EN
    , .line_cnt(line_cnt), .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  // datapath model: only the cycle before the expected capture edge carries real results
  assign lines_out = dp_good ? good_vec : {(RD*RW){8'hEE}};
  function automatic logic [DW*RD-1:0] exp_col(input int j);
    logic [DW*RD-1:0] v;
    for (int i = 0; i < RD; i++) v[i*DW +: DW] = 8'(i*30 + j);
    return v;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_line(input int last_at, input int err_at);
    int bad, early;
    bad = 0;
    early = 0;
    for (int w = 0; w < W; w++) begin
      in_valid = 1'b1;
      in_last = (w == last_at);
      for (int k = 0; k < D; k++) in_data[k*DW +: DW] = 8'(w + k);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready beat %0d: got %b want 1", w, in_ready); end
      tick;
      if (w == err_at) begin
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_rise beat %0d: got %b want 1", w, err); end
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    for (int k = 0; k < D; k++)
      for (int w = 0; w < W; w++)
        if (lines_in[(k*W + w)*DW +: DW] !== 8'(w + k)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL lines_in: %0d bad elements, want 0", bad); end
    for (int e = 1; e < LAT; e++) begin
      tick;
      if (out_valid !== 1'b0) early++;
    end
    dp_good = 1'b1;
    tick;
    dp_good = 1'b0;
    checks++;
    if (early != 0 || out_valid !== 1'b1)
      begin errors++; $display("FAIL capture_latency: early=%0d out_valid=%b want early=0 out_valid=1", early, out_valid); end
  endtask
  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: two stall cycles then ready
  task automatic drain_line(input int mode);
    int j, c;
    j = 0;
    c = 0;
    while (j < RW && c < 300) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 4 == 0 || c % 4 == 3) : (c >= 2);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_col(j) || out_last !== (j == RW - 1)) begin
        errors++;
        $display("FAIL drain col %0d: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                 j, out_valid, out_data, out_last, exp_col(j), j == RW - 1);
      end
      tick;
      if (out_ready) j++;
      c++;
    end
    out_ready = 1'b0;
    checks++;
    if (c >= 300) begin errors++; $display("FAIL drain_timeout: got %0d cols want %0d", j, RW); end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL drain_return: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0)
      begin errors++; $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_last=%b want 0 0 0", in_ready, out_valid, out_last); end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || err !== 1'b0 || out_valid !== 1'b0 || lines_in !== '0)
      begin errors++; $display("FAIL post_reset: in_ready=%b err=%b out_valid=%b lines_in_zero=%b want 1 0 0 1", in_ready, err, out_valid, lines_in == '0); end
  endtask
  task automatic test_basic;
    run_line(31, -1);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err); end
    drain_line(0);
  endtask
  task automatic test_stall;
    run_line(31, -1);
    drain_line(1);
  endtask
  task automatic test_framing_err;
    run_line(10, 10);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky_load: got %b want 1", err); end
    drain_line(0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky_drain: got %b want 1", err); end
  endtask
  task automatic test_reset_drain;
    test_reset;
    run_line(31, -1);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_col(j))
        begin errors++; $display("FAIL pre_reset col %0d: valid=%b data=%h want 1 %h", j, out_valid, out_data, exp_col(j)); end
      tick;
    end
    checks++;
    if (out_data !== exp_col(5)) begin errors++; $display("FAIL at_col5: got %h want %h", out_data, exp_col(5)); end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL during_reset: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready); end
    tick;
    reset = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0)
      begin errors++; $display("FAIL after_reset: out_valid=%b in_ready=%b err=%b want 0 1 0", out_valid, in_ready, err); end
    run_line(31, -1);
    drain_line(0);
  endtask
`ifdef CONV1D_SCHED_PERF_EN
  task automatic test_perf;
    test_reset;
    checks++;
    if (line_cnt !== 32'd0 || stall_cnt !== 32'd0)
      begin errors++; $display("FAIL perf_reset: line=%0d stall=%0d want 0 0", line_cnt, stall_cnt); end
    run_line(31, -1);
    drain_line(2);
    run_line(31, -1);
    drain_line(2);
    checks++;
    if (line_cnt !== 32'd2 || stall_cnt !== 32'd4)
      begin errors++; $display("FAIL perf_counts: line=%0d stall=%0d want 2 4", line_cnt, stall_cnt); end
  endtask
`endif
  initial begin
    for (int i = 0; i < RD; i++)
      for (int j = 0; j < RW; j++) good_vec[(i*RW + j)*DW +: DW] = 8'(i*30 + j);
    test_reset;
    test_basic;
    test_stall;
    test_framing_err;
    test_reset_drain;
`ifdef CONV1D_SCHED_PERF_EN
    test_perf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
